// File: rtl/mem_stage_sram_pkg.sv
// Shared types and defaults for the MEM stage with 16-bit SRAM interface.
package mem_stage_sram_pkg;

  localparam int unsigned AccessCyclesDefault = 2;
  localparam int unsigned BaseAddrDefault     = 1024;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWrLo = 3'd1,
    StWrHi = 3'd2,
    StRdLo = 3'd3,
    StRdHi = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// 4-bit wait-state counter with synchronous clear; saturates at the terminal count.
module sram_wait_counter #(
  parameter logic [3:0] TermCount = 4'd1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tc
);

  logic [3:0] r_cnt;

  // Count up from zero after each clear, holding at the terminal value
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= 4'd0;
    end else if (r_cnt != TermCount) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tc = (r_cnt == TermCount);

endmodule

// File: rtl/mem_stage_sram.sv
// MEM pipeline stage: splits 32-bit loads/stores into two 16-bit SRAM accesses
// and stalls the upstream pipeline until the access sequence is done.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = AccessCyclesDefault,
  parameter int unsigned BASE_ADDR     = BaseAddrDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnIn,
  input  logic        memREnIn,
  input  logic        memWEnIn,
  input  logic [31:0] aluRes,
  input  logic [31:0] valRm,
  input  logic [3:0]  dest,
  output logic        wbEnOut,
  output logic        memREnOut,
  output logic [31:0] aluResOut,
  output logic [3:0]  destOut,
  output logic [31:0] memData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  input  logic [15:0] sramDqIn,
  output logic        sramDqOe,
  output logic        sramWeN
);

  localparam logic [3:0] TermCount = 4'(ACCESS_CYCLES - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic        w_cnt_clr;
  logic        w_tc;
  logic [17:0] w_addr_lo;
  logic [17:0] w_addr_hi;
  logic [31:0] r_mem_data;

  // Halfword address; out-of-window addresses simply wrap
  assign w_addr_lo = 18'((aluRes - BASE_ADDR) >> 1);
  assign w_addr_hi = w_addr_lo + 18'd1;

  // Counter restarts whenever the FSM changes state
  assign w_cnt_clr = (w_state_next != r_state);

  sram_wait_counter #(
    .TermCount(TermCount)
  ) u_wait_counter (
    .i_clk(clk),
    .i_rst(rst),
    .i_clr(w_cnt_clr),
    .o_tc (w_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a write wins when both enables are set
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (memWEnIn) begin
          w_state_next = StWrLo;
        end else if (memREnIn) begin
          w_state_next = StRdLo;
        end
      end
      StWrLo: if (w_tc) w_state_next = StWrHi;
      StWrHi: if (w_tc) w_state_next = StDone;
      StRdLo: if (w_tc) w_state_next = StRdHi;
      StRdHi: if (w_tc) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // SRAM pin drive; forced idle while rst is high so no write leaks out mid-reset
  always_comb begin
    sramAddr  = 18'd0;
    sramDqOut = 16'd0;
    sramWeN   = 1'b1;
    sramDqOe  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StWrLo: begin
          sramAddr  = w_addr_lo;
          sramDqOut = valRm[15:0];
          sramWeN   = 1'b0;
          sramDqOe  = 1'b1;
        end
        StWrHi: begin
          sramAddr  = w_addr_hi;
          sramDqOut = valRm[31:16];
          sramWeN   = 1'b0;
          sramDqOe  = 1'b1;
        end
        StRdLo: sramAddr = w_addr_lo;
        StRdHi: sramAddr = w_addr_hi;
        default: ;
      endcase
    end
  end

  // Load data capture on the final wait cycle of each read half
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_data <= 32'd0;
    end else if (r_state == StRdLo && w_tc) begin
      r_mem_data[15:0] <= sramDqIn;
    end else if (r_state == StRdHi && w_tc) begin
      r_mem_data[31:16] <= sramDqIn;
    end
  end

  assign memData   = r_mem_data;
  assign ready     = ~(memREnIn | memWEnIn) | (r_state == StDone);
  // Frozen cycles hand a bubble to MEM/WB
  assign wbEnOut   = wbEnIn & ready;
  assign memREnOut = memREnIn & ready;
  assign aluResOut = aluRes;
  assign destOut   = dest;

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam int unsigned Ac   = 2;
  localparam int unsigned Base = 1024;

  typedef struct {
    int unsigned ready_cyc;
    logic [31:0] data;
    logic        wb;
    logic        mre;
    int unsigned we_cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbEnIn, memREnIn, memWEnIn;
  logic [31:0] aluRes, valRm;
  logic [3:0]  dest;
  logic        wbEnOut, memREnOut, ready, sramDqOe, sramWeN;
  logic [31:0] aluResOut, memData;
  logic [3:0]  destOut;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;

  logic        d1_memREnIn;
  logic [31:0] d1_aluRes;
  logic        d1_wbEnOut, d1_memREnOut, d1_ready, d1_sramDqOe, d1_sramWeN;
  logic [31:0] d1_aluResOut, d1_memData;
  logic [3:0]  d1_destOut;
  logic [17:0] d1_sramAddr;
  logic [15:0] d1_sramDqOut;

  logic [15:0] sram_mem [0:262143];
  logic [15:0] exp_mem  [int];
  logic [31:0] exp_rd;
  exp_t        sb_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mem_stage_sram #(
    .ACCESS_CYCLES(Ac),
    .BASE_ADDR    (Base)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wbEnIn   (wbEnIn),
    .memREnIn (memREnIn),
    .memWEnIn (memWEnIn),
    .aluRes   (aluRes),
    .valRm    (valRm),
    .dest     (dest),
    .wbEnOut  (wbEnOut),
    .memREnOut(memREnOut),
    .aluResOut(aluResOut),
    .destOut  (destOut),
    .memData  (memData),
    .ready    (ready),
    .sramAddr (sramAddr),
    .sramDqOut(sramDqOut),
    .sramDqIn (sramDqIn),
    .sramDqOe (sramDqOe),
    .sramWeN  (sramWeN)
  );

  mem_stage_sram #(
    .ACCESS_CYCLES(1),
    .BASE_ADDR    (Base)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .wbEnIn   (1'b1),
    .memREnIn (d1_memREnIn),
    .memWEnIn (1'b0),
    .aluRes   (d1_aluRes),
    .valRm    (32'd0),
    .dest     (4'd0),
    .wbEnOut  (d1_wbEnOut),
    .memREnOut(d1_memREnOut),
    .aluResOut(d1_aluResOut),
    .destOut  (d1_destOut),
    .memData  (d1_memData),
    .ready    (d1_ready),
    .sramAddr (d1_sramAddr),
    .sramDqOut(d1_sramDqOut),
    .sramDqIn (16'h1234),
    .sramDqOe (d1_sramDqOe),
    .sramWeN  (d1_sramWeN)
  );

  // SRAM model: asynchronous read, write committed on each clock with WE# low
  assign sramDqIn = sram_mem[sramAddr];
  always @(posedge clk) begin
    if (!sramWeN) sram_mem[sramAddr] <= sramDqOut;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [17:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 16'h0000;
  endfunction

  task automatic set_idle();
    wbEnIn = 1'b0; memREnIn = 1'b0; memWEnIn = 1'b0;
    aluRes = 32'd0; valRm = 32'd0; dest = 4'd0;
  endtask

  // Issue one instruction right after a clock edge and follow it to completion
  task automatic do_op(input logic we, input logic re, input logic wb,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] d);
    exp_t        e;
    logic [17:0] a;
    int unsigned cyc;
    int unsigned we_cnt;
    logic        got;
    logic        frz_wb;
    a = 18'((alu - 32'(Base)) >> 1);
    if (we) begin
      exp_mem[int'(a)]         = val[15:0];
      exp_mem[int'(a + 18'd1)] = val[31:16];
    end else if (re) begin
      exp_rd = {model_rd(a + 18'd1), model_rd(a)};
    end
    e.ready_cyc = (we || re) ? 2 * Ac + 2 : 1;
    e.data      = exp_rd;
    e.wb        = wb;
    e.mre       = re;
    e.we_cycles = we ? 2 * Ac : 0;
    sb_q.push_back(e);
    wbEnIn = wb; memREnIn = re; memWEnIn = we;
    aluRes = alu; valRm = val; dest = d;
    cyc = 0; we_cnt = 0; got = 1'b0; frz_wb = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!sramWeN) we_cnt++;
      if (ready) got = 1'b1;
      else if (wbEnOut) frz_wb = 1'b1;
    end
    check("ready_seen", 32'(got), 32'd1);
    e = sb_q.pop_front();
    check("ready_cycle", cyc, e.ready_cyc);
    check("mem_data", memData, e.data);
    check("wb_en_out", 32'(wbEnOut), 32'(e.wb));
    check("mem_ren_out", 32'(memREnOut), 32'(e.mre));
    check("wb_frozen_bubble", 32'(frz_wb), 32'd0);
    check("we_low_cycles", we_cnt, e.we_cycles);
    check("alu_res_out", aluResOut, alu);
    check("dest_out", 32'(destOut), 32'(d));
    @(posedge clk);
    #1;
    set_idle();
  endtask

  initial begin
    logic [31:0] adr;
    logic [31:0] val;
    logic [15:0] old_hi;
    set_idle();
    d1_memREnIn = 1'b0;
    d1_aluRes   = 32'd0;
    exp_rd      = 32'd0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wen", 32'(sramWeN), 32'd1);
    check("rst_oe", 32'(sramDqOe), 32'd0);
    check("rst_addr", 32'(sramAddr), 32'd0);
    check("rst_mem_data", memData, 32'd0);
    check("rst_ready_idle", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU op: no stall, SRAM untouched
    do_op(1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 4'd7);
    // Store then load back
    do_op(1'b1, 1'b0, 1'b0, 32'd1024, 32'hDEAD_BEEF, 4'd1);
    check("sram_hw0", 32'(sram_mem[0]), 32'h0000_BEEF);
    check("sram_hw1", 32'(sram_mem[1]), 32'h0000_DEAD);
    do_op(1'b0, 1'b1, 1'b1, 32'd1024, 32'h0, 4'd2);
    // Both enables: write wins, memData untouched
    do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'd5, 4'd3);
    check("sram_hw2", 32'(sram_mem[2]), 32'd5);
    check("sram_hw3", 32'(sram_mem[3]), 32'd0);

    // Random store/load pairs
    for (int i = 0; i < 6; i++) begin
      adr = 32'(Base) + 32'($urandom_range(4, 2000)) * 4;
      val = $urandom;
      do_op(1'b1, 1'b0, 1'b0, adr, val, 4'(i));
      do_op(1'b0, 1'b1, 1'b1, adr, 32'h0, 4'(i + 8));
    end

    // Reset in the third cycle of a store
    old_hi = sram_mem[9];
    memWEnIn = 1'b1; aluRes = 32'd1040; valRm = 32'hAAAA_5555;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wen", 32'(sramWeN), 32'd1);
    check("midrst_oe", 32'(sramDqOe), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("postrst_wen", 32'(sramWeN), 32'd1);
    check("postrst_addr", 32'(sramAddr), 32'd0);
    check("postrst_mem_data", memData, 32'd0);
    check("postrst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    check("postrst_wen_idle", 32'(sramWeN), 32'd1);
    @(posedge clk);
    #1;
    check("no_hi_write", 32'(sram_mem[9]), 32'(old_hi));
    exp_rd = 32'd0;
    exp_mem[8] = 16'h5555;
    do_op(1'b0, 1'b1, 1'b1, 32'd1024, 32'h0, 4'd4);

    // Single-cycle access instance, address below the SRAM window
    d1_memREnIn = 1'b1;
    d1_aluRes   = 32'd0;
    @(negedge clk);
    check("d1_c1_ready", 32'(d1_ready), 32'd0);
    @(negedge clk);
    check("d1_c2_addr", 32'(d1_sramAddr), 32'h3FE00);
    @(negedge clk);
    check("d1_c3_addr", 32'(d1_sramAddr), 32'h3FE01);
    check("d1_c3_ready", 32'(d1_ready), 32'd0);
    @(negedge clk);
    check("d1_c4_ready", 32'(d1_ready), 32'd1);
    check("d1_c4_data", d1_memData, 32'h1234_1234);
    @(posedge clk);
    #1;
    d1_memREnIn = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
